ball_draw_sequencer: RTL and testbench
======================================

# ball_draw_sequencer

Frame-level draw scheduler that sits directly upstream of ball_render. On each frame tick it drives the clear-old, draw-new and black-screen requests as held levels and waits for the matching done pulses. It freezes ball physics during a post-score blank-and-pause interval and produces the VGA plot strobe. It also counts overrun frames and times out stalled draws.

## Interface
- FRAME_RATE, 15: frame ticks per second; sizes the pause counter.
- PAUSE_FRAMES, 30: frames held frozen after a score blank; 0 means no pause.
- DONE_TIMEOUT, 400000: maximum cycles to wait for any done pulse.
- PLOT_DELAY, 1: pipeline depth from request level to plot; must be ≥1.
- CNT_W, 8: width of the overrun counter.
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- frameTick  in  1  single-cycle frame strobe.
- score_event  in  1  lhs_scored OR rhs_scored; may stay high for several cycles.
- done_clearOld, done_drawNew, done_blackScreen  in  1 each  single-cycle done pulses from ball_render.
- clearOld_pulse, drawNew_pulse, blackScreen_pulse  out  1 each  request levels to ball_render, registered.
- game_enable  out  1  enable for ball_physics and control_ball_movement.
- plot  out  1  VGA write enable.
- busy  out  1  high in any state other than S_IDLE.
- overrun_cnt  out  CNT_W  saturating count of frameTicks that arrived while busy.
- timeout_err  out  1  sticky; set on watchdog expiry.

## Operation
- States:
  - S_BLACK: blackScreen_pulse=1, game_enable=0.
  - S_PAUSE: game_enable=0.
  - S_IDLE: game_enable=1.
  - S_CLEAR: clearOld_pulse=1, game_enable=1.
  - S_DRAW: drawNew_pulse=1, game_enable=1.
- Outputs are Moore and decoded from the registered state. Exactly one request level is high at any time.
- Reset: state is S_BLACK on the first cycle after resetn goes high. Every output is 0 while resetn=0.
- S_BLACK → S_PAUSE on done_blackScreen, or → S_IDLE if PAUSE_FRAMES=0. Clears score_pending and loads pause_cnt=PAUSE_FRAMES.
- S_PAUSE: decrements pause_cnt on each frameTick. Goes to S_IDLE on the tick that takes the count to 0.
- S_IDLE, on frameTick:
  - score_pending=1 → S_BLACK.
  - otherwise → S_CLEAR.
- S_CLEAR → S_DRAW on done_clearOld.
- S_DRAW → S_IDLE on done_drawNew.
- score_pending is set when score_event is high in any state other than S_BLACK or S_PAUSE. It is serviced only at the next frame boundary, so the current clear/draw always completes.
- Watchdog:
  - wd_cnt resets to 0 on every state change.
  - It increments in S_BLACK, S_CLEAR and S_DRAW.
  - When wd_cnt reaches DONE_TIMEOUT: timeout_err←1, state → S_IDLE, request levels drop.
  - timeout_err clears only on reset.
- overrun_cnt increments when frameTick=1 and state≠S_IDLE. Exception: S_PAUSE ticks are expected and are not counted. It saturates at 2^CNT_W−1.
- A done pulse arriving in a state that does not wait for it is ignored.

## Timing
- frameTick at cycle t in S_IDLE → clearOld_pulse=1 at t+1.
- done_clearOld at t → clearOld_pulse=0 and drawNew_pulse=1 at t+1. There is no gap cycle.
- done_drawNew at t → drawNew_pulse=0 and busy=0 at t+1. A frameTick at t+1 is accepted.
- plot equals OR(clearOld_pulse, drawNew_pulse, blackScreen_pulse) delayed by PLOT_DELAY cycles. This matches the one-cycle output register in ball_render.
- On exit from a request state, plot stays high for PLOT_DELAY more cycles.
- score_event and frameTick in the same cycle while in S_IDLE → next state is S_BLACK.
- resetn low mid-draw: all outputs 0 on the next edge, and the plot pipeline is flushed.

## Structure
- Shared package pong_pkg holds:
  - the state encoding typedef: 3-bit, S_IDLE=0, S_CLEAR=1, S_DRAW=2, S_BLACK=3, S_PAUSE=4;
  - default PAUSE_FRAMES and DONE_TIMEOUT.
- Sub-module plot_delay_line: a PLOT_DELAY-deep shift register with synchronous clear.
- Everything else is flat: FSM, pending latch, pause counter, watchdog, overrun counter.

## Test plan
- Reset release → blackScreen_pulse=1 at cycle 1. Pulse done_blackScreen at cycle 50 → S_PAUSE. After 30 frameTicks → S_IDLE and game_enable=1.
- frameTick in S_IDLE; done_clearOld 16 cycles later; done_drawNew 16 cycles after that → clearOld_pulse high for 16 cycles, then drawNew_pulse high for 16 cycles, plot delayed 1 cycle, busy low afterwards.
- score_event pulsed mid-S_DRAW → draw finishes. Next frameTick → blackScreen_pulse=1 and game_enable=0.
- Three frameTicks during one long S_DRAW → overrun_cnt=3. With CNT_W=2 and 5 ticks → overrun_cnt=3 (saturated).
- DONE_TIMEOUT=100 and no done_clearOld → clearOld_pulse drops after 100 cycles, timeout_err=1, state S_IDLE.
- resetn low for 1 cycle mid-S_CLEAR → all outputs 0, then re-entry into S_BLACK.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong frame pipeline: draw-scheduler state encoding
// and default timing constants.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_DRAW  = 3'd2,
    S_BLACK = 3'd3,
    S_PAUSE = 3'd4
  } state_e;

  localparam int unsigned DEF_PAUSE_FRAMES = 30;
  localparam int unsigned DEF_DONE_TIMEOUT = 400000;

  // States that hold a request level to ball_render and wait for its done pulse.
  function automatic logic is_request(state_e s);
    return (s == S_CLEAR) || (s == S_DRAW) || (s == S_BLACK);
  endfunction

endpackage

// File: rtl/plot_delay_line.sv
// Fixed-depth single-bit shift register with synchronous clear; aligns the VGA
// plot strobe with the pixel pipeline inside ball_render.
module plot_delay_line #(
  parameter int unsigned STAGES = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr_q;

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (clr) sr_q <= '0;
        else     sr_q <= d;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (clr) sr_q <= '0;
        else     sr_q <= {sr_q[STAGES-2:0], d};
      end
    end
  endgenerate

  assign q = sr_q[STAGES-1];

endmodule

// File: rtl/ball_draw_sequencer.sv
// Frame-level draw scheduler ahead of ball_render: sequences clear/draw/blank
// requests, freezes physics after a score, and guards against stalled draws.
module ball_draw_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned FRAME_RATE   = 15,
  parameter int unsigned PAUSE_FRAMES = DEF_PAUSE_FRAMES,
  parameter int unsigned DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter int unsigned PLOT_DELAY   = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frameTick,
  input  logic             score_event,
  input  logic             done_clearOld,
  input  logic             done_drawNew,
  input  logic             done_blackScreen,
  output logic             clearOld_pulse,
  output logic             drawNew_pulse,
  output logic             blackScreen_pulse,
  output logic             game_enable,
  output logic             plot,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             timeout_err
);

  // Pause counter is wide enough for at least one second of frames.
  localparam int unsigned PAUSE_MAX = (PAUSE_FRAMES > FRAME_RATE) ? PAUSE_FRAMES : FRAME_RATE;
  localparam int unsigned PAUSE_W   = $clog2(PAUSE_MAX + 1);
  localparam int unsigned WD_W      = $clog2(DONE_TIMEOUT + 1);

  localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_FRAMES);
  localparam logic [PAUSE_W-1:0] PAUSE_ONE  = PAUSE_W'(1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   OVR_MAX    = '1;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [CNT_W-1:0]   ovr_q, ovr_d;
  logic               terr_q, terr_d;
  logic               clr_q, drw_q, blk_q, ge_q, busy_q;
  logic               wd_expired;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pause_d    = pause_q;
    ovr_d      = ovr_q;
    terr_d     = terr_q;
    wd_expired = is_request(state_q) && (wd_q == WD_LAST);

    if (score_event && (state_q != S_BLACK) && (state_q != S_PAUSE)) pend_d = 1'b1;
    if (frameTick && (state_q != S_IDLE) && (state_q != S_PAUSE) && (ovr_q != OVR_MAX))
      ovr_d = ovr_q + 1'b1;

    case (state_q)
      S_BLACK: begin
        if (done_blackScreen) begin
          pend_d  = 1'b0;
          pause_d = PAUSE_LOAD;
          state_d = (PAUSE_FRAMES == 0) ? S_IDLE : S_PAUSE;
        end else if (wd_expired) begin
          pend_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (frameTick) begin
          pause_d = pause_q - 1'b1;
          if (pause_q == PAUSE_ONE) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        // A score seen in this very cycle still diverts the frame to a blank.
        if (frameTick) state_d = (pend_q || score_event) ? S_BLACK : S_CLEAR;
      end
      S_CLEAR: begin
        if (done_clearOld) state_d = S_DRAW;
        else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAW: begin
        if (done_drawNew) state_d = S_IDLE;
        else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)        wd_d = '0;
    else if (is_request(state_q))  wd_d = wd_q + 1'b1;
    else                           wd_d = '0;
  end

  // Outputs are registered from the next state so they track state_q exactly,
  // yet read all-zero while reset is held.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_BLACK;
      pend_q  <= 1'b0;
      pause_q <= '0;
      wd_q    <= '0;
      ovr_q   <= '0;
      terr_q  <= 1'b0;
      clr_q   <= 1'b0;
      drw_q   <= 1'b0;
      blk_q   <= 1'b0;
      ge_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pause_q <= pause_d;
      wd_q    <= wd_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
      clr_q   <= (state_d == S_CLEAR);
      drw_q   <= (state_d == S_DRAW);
      blk_q   <= (state_d == S_BLACK);
      ge_q    <= (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DRAW);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  plot_delay_line #(
    .STAGES(PLOT_DELAY)
  ) u_plot_delay (
    .clk(clk),
    .clr(!resetn),
    .d  (clr_q | drw_q | blk_q),
    .q  (plot)
  );

  assign clearOld_pulse    = clr_q;
  assign drawNew_pulse     = drw_q;
  assign blackScreen_pulse = blk_q;
  assign game_enable       = ge_q;
  assign busy              = busy_q;
  assign overrun_cnt       = ovr_q;
  assign timeout_err       = terr_q;

endmodule

// File: tb/tb_ball_draw_sequencer.sv
// Scoreboard bench for ball_draw_sequencer: directed frame scenarios followed by
// randomized traffic, each cycle checked against a frame-level reference model.
module tb_ball_draw_sequencer;

  localparam int PF    = 4;
  localparam int TO    = 100;
  localparam int PD    = 2;
  localparam int CW    = 2;
  localparam int OVMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0, frameTick = 1'b0, score_event = 1'b0;
  logic done_clearOld = 1'b0, done_drawNew = 1'b0, done_blackScreen = 1'b0;
  logic clearOld_pulse, drawNew_pulse, blackScreen_pulse, game_enable, plot, busy, timeout_err;
  logic [CW-1:0] overrun_cnt;

  ball_draw_sequencer #(
    .FRAME_RATE(15), .PAUSE_FRAMES(PF), .DONE_TIMEOUT(TO), .PLOT_DELAY(PD), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .frameTick(frameTick), .score_event(score_event),
    .done_clearOld(done_clearOld), .done_drawNew(done_drawNew),
    .done_blackScreen(done_blackScreen),
    .clearOld_pulse(clearOld_pulse), .drawNew_pulse(drawNew_pulse),
    .blackScreen_pulse(blackScreen_pulse), .game_enable(game_enable), .plot(plot),
    .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_CLEAR, M_DRAW, M_BLACK, M_PAUSE} mode_t;
  typedef struct {
    bit c, d, b, ge, busy, terr, plot;
    int ovr;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: which frame phase we are in and the bookkeeping
  // the rules require (pending score, frames left to pause, cycles waited).
  mode_t st = M_BLACK;
  bit    live = 0, pend = 0, terr = 0;
  int    waited = 0, frames_left = 0, ovr = 0;
  bit    req_hist[$];

  task automatic model_step();
    mode_t nxt;
    bit    req_now;
    exp_t  e;
    req_now = live && (st == M_CLEAR || st == M_DRAW || st == M_BLACK);
    if (!resetn) begin
      st = M_BLACK; live = 0; pend = 0; terr = 0; waited = 0; frames_left = 0; ovr = 0;
      req_hist.delete();
      repeat (PD) req_hist.push_back(1'b0);
    end else begin
      nxt = st;
      if (frameTick && st != M_IDLE && st != M_PAUSE && ovr < OVMAX) ovr++;
      if (score_event && st != M_BLACK && st != M_PAUSE) pend = 1;
      case (st)
        M_BLACK:
          if (done_blackScreen) begin
            pend = 0; frames_left = PF; nxt = (PF == 0) ? M_IDLE : M_PAUSE;
          end else if (waited == TO - 1) begin
            pend = 0; terr = 1; nxt = M_IDLE;
          end
        M_PAUSE:
          if (frameTick) begin
            frames_left--;
            if (frames_left == 0) nxt = M_IDLE;
          end
        M_IDLE:  if (frameTick) nxt = pend ? M_BLACK : M_CLEAR;
        M_CLEAR:
          if (done_clearOld) nxt = M_DRAW;
          else if (waited == TO - 1) begin terr = 1; nxt = M_IDLE; end
        M_DRAW:
          if (done_drawNew) nxt = M_IDLE;
          else if (waited == TO - 1) begin terr = 1; nxt = M_IDLE; end
        default: nxt = M_IDLE;
      endcase
      if (nxt != st) waited = 0;
      else if (st == M_CLEAR || st == M_DRAW || st == M_BLACK) waited++;
      else waited = 0;
      req_hist.push_back(req_now);
      void'(req_hist.pop_front());
      st = nxt;
      live = 1;
    end
    e.c    = live && st == M_CLEAR;
    e.d    = live && st == M_DRAW;
    e.b    = live && st == M_BLACK;
    e.ge   = live && (st == M_IDLE || st == M_CLEAR || st == M_DRAW);
    e.busy = live && st != M_IDLE;
    e.terr = terr;
    e.ovr  = ovr;
    e.plot = req_hist[0];
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (PD) req_hist.push_back(1'b0);
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expected vector per clock edge, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("clearOld_pulse", 32'(clearOld_pulse), 32'(e.c));
        chk("drawNew_pulse", 32'(drawNew_pulse), 32'(e.d));
        chk("blackScreen_pulse", 32'(blackScreen_pulse), 32'(e.b));
        chk("game_enable", 32'(game_enable), 32'(e.ge));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("plot", 32'(plot), 32'(e.plot));
        chk("timeout_err", 32'(timeout_err), 32'(e.terr));
        chk("overrun_cnt", 32'(overrun_cnt), e.ovr);
      end
    end
  end

  task automatic step(input bit rn, input bit ft, input bit se,
                      input bit dc, input bit dd, input bit db);
    resetn = rn; frameTick = ft; score_event = se;
    done_clearOld = dc; done_drawNew = dd; done_blackScreen = db;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic pause_ticks(input int n);
    repeat (n) begin
      step(1, 1, 0, 0, 0, 0);
      idle(9);
    end
  endtask

  initial begin
    int dens[3] = '{6, 20, 150};
    int dn;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    // Power-up blank, pause, then one ordinary frame.
    idle(49);
    step(1, 0, 0, 0, 0, 1);
    pause_ticks(PF);
    idle(5);
    step(1, 1, 0, 0, 0, 0);
    idle(15);
    step(1, 0, 0, 1, 0, 0);
    idle(15);
    step(1, 0, 0, 0, 1, 0);
    idle(3);
    // Score during a draw is deferred to the next frame.
    step(1, 1, 0, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 1, 0, 0);
    idle(5);
    step(1, 0, 1, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 1, 0);
    idle(3);
    step(1, 1, 0, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 0, 1);
    pause_ticks(PF);
    // Five ticks during one long draw saturate the 2-bit overrun counter.
    step(1, 1, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 1, 0, 0);
    repeat (5) begin
      step(1, 1, 0, 0, 0, 0);
      idle(2);
    end
    step(1, 0, 0, 0, 1, 0);
    idle(3);
    // Stalled clear trips the watchdog.
    step(1, 1, 0, 0, 0, 0);
    idle(110);
    // Reset pulse in the middle of a clear.
    step(1, 1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 0, 0);
    idle(20);
    step(1, 0, 0, 0, 0, 1);
    pause_ticks(PF);
    // Tick and score together while idle go straight to a blank.
    idle(2);
    step(1, 1, 1, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0, 1);
    pause_ticks(PF);
    // Random traffic with varying done-pulse density, including stray dones.
    for (int blk = 0; blk < 9; blk++) begin
      dn = dens[blk % 3];
      repeat (400)
        step($urandom_range(0, 499) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, dn) == 0,
             $urandom_range(0, dn) == 0, $urandom_range(0, dn) == 0);
    end
    idle(4);
    @(negedge clk);
    @(negedge clk);
    if (vectors == 0) begin
      miscompares++;
      $display("FAIL vectors: got 0 expected nonzero");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
